// File: rtl/b_calc_ctrl.sv
// b_calc_ctrl: top-level sequencer for the 8-bit integer calculator.
//
// Collects operand A from the keypad block, then an operator, then operand
// B, and runs the calculation on an external ALU over a req/ack handshake.
// The result can be chained into a new calculation with another operator.
// Every output is driven straight from a flop.
//
// State table:
//   S_IDLE    (0) | display 0, waiting for the first digit
//   S_ENTER_A (1) | keypad value tracks operand A; operator latches it
//   S_ENTER_B (3) | shows operand A until the first digit, then operand B
//   S_EXEC    (4) | ALU request held until ack or timeout
//   S_RESULT  (5) | result shown; operator chains, digit starts over
//   S_ERROR   (6) | display EEEE; only clear leaves
//   2, 7          | unused; fall back to S_IDLE
//
// Ports:
//   i_sys_clock / i_sys_reset            clock, synchronous active-high reset
//   i_b_calc_ctrl_keycode                accumulated keypad operand
//   i_b_calc_ctrl_new_input              digit accepted pulse
//   i_b_calc_ctrl_overflow_flag          keypad operand overflow (level)
//   i_b_calc_ctrl_op_key / _op_code      operator pulse and operator code
//   i_b_calc_ctrl_eq_key / _clr_key      equals and clear pulses
//   i_b_calc_ctrl_alu_ack/_result/_error ALU response
//   o_b_calc_ctrl_hex_clear              pulse to clear the keypad operand
//   o_b_calc_ctrl_op_valid_key_pressed   pulse to keypad operator input
//   o_b_calc_ctrl_alu_req                ALU request level
//   o_b_calc_ctrl_operand_a/_b/_opcode   latched calculation inputs
//   o_b_calc_ctrl_display                value to display
//   o_b_calc_ctrl_state / _error         current state, error indicator

module b_calc_ctrl #(
    parameter int P_TIMEOUT_CYCLES = 16,
    parameter int P_RESULT_W       = 16
) (
    input  logic                  i_sys_clock,
    input  logic                  i_sys_reset,
    input  logic [7:0]            i_b_calc_ctrl_keycode,
    input  logic                  i_b_calc_ctrl_new_input,
    input  logic                  i_b_calc_ctrl_overflow_flag,
    input  logic                  i_b_calc_ctrl_op_key,
    input  logic [1:0]            i_b_calc_ctrl_op_code,
    input  logic                  i_b_calc_ctrl_eq_key,
    input  logic                  i_b_calc_ctrl_clr_key,
    input  logic                  i_b_calc_ctrl_alu_ack,
    input  logic [P_RESULT_W-1:0] i_b_calc_ctrl_alu_result,
    input  logic                  i_b_calc_ctrl_alu_error,
    output logic                  o_b_calc_ctrl_hex_clear,
    output logic                  o_b_calc_ctrl_op_valid_key_pressed,
    output logic                  o_b_calc_ctrl_alu_req,
    output logic [7:0]            o_b_calc_ctrl_operand_a,
    output logic [7:0]            o_b_calc_ctrl_operand_b,
    output logic [1:0]            o_b_calc_ctrl_opcode,
    output logic [P_RESULT_W-1:0] o_b_calc_ctrl_display,
    output logic [2:0]            o_b_calc_ctrl_state,
    output logic                  o_b_calc_ctrl_error
);

    localparam int CNT_W = $clog2(P_TIMEOUT_CYCLES + 1);
    // The counter starts at 0 on the first request cycle, so the last
    // permitted cycle without an ack is P_TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(P_TIMEOUT_CYCLES - 1);
    localparam logic [P_RESULT_W-1:0] DISP_ERR = P_RESULT_W'(16'hEEEE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER_A = 3'd1,
        S_UNUSED2 = 3'd2,
        S_ENTER_B = 3'd3,
        S_EXEC    = 3'd4,
        S_RESULT  = 3'd5,
        S_ERROR   = 3'd6,
        S_UNUSED7 = 3'd7
    } state_t;

    state_t                state, state_nxt;
    logic                  got_b, got_b_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [7:0]            operand_a, operand_a_nxt;
    logic [7:0]            operand_b, operand_b_nxt;
    logic [1:0]            opcode, opcode_nxt;
    logic [P_RESULT_W-1:0] display, display_nxt;
    logic                  alu_req, alu_req_nxt;
    logic                  hex_clear, hex_clear_nxt;
    logic                  op_pulse, op_pulse_nxt;
    logic                  error, error_nxt;
    logic [P_RESULT_W-1:0] key_ext;

    assign key_ext = {{(P_RESULT_W-8){1'b0}}, i_b_calc_ctrl_keycode};

    always_ff @(posedge i_sys_clock) begin
        if (i_sys_reset) begin
            state     <= S_IDLE;
            got_b     <= 1'b0;
            cnt       <= '0;
            operand_a <= '0;
            operand_b <= '0;
            opcode    <= '0;
            display   <= '0;
            alu_req   <= 1'b0;
            hex_clear <= 1'b0;
            op_pulse  <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            got_b     <= got_b_nxt;
            cnt       <= cnt_nxt;
            operand_a <= operand_a_nxt;
            operand_b <= operand_b_nxt;
            opcode    <= opcode_nxt;
            display   <= display_nxt;
            alu_req   <= alu_req_nxt;
            hex_clear <= hex_clear_nxt;
            op_pulse  <= op_pulse_nxt;
            error     <= error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        got_b_nxt     = got_b;
        cnt_nxt       = cnt;
        operand_a_nxt = operand_a;
        operand_b_nxt = operand_b;
        opcode_nxt    = opcode;
        display_nxt   = display;
        alu_req_nxt   = 1'b0;
        hex_clear_nxt = 1'b0;
        op_pulse_nxt  = 1'b0;

        if (i_b_calc_ctrl_clr_key) begin
            state_nxt     = S_IDLE;
            hex_clear_nxt = 1'b1;
            cnt_nxt       = '0;
            operand_a_nxt = '0;
            operand_b_nxt = '0;
            opcode_nxt    = '0;
            display_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    display_nxt = '0;
                    if (i_b_calc_ctrl_new_input) begin
                        state_nxt   = S_ENTER_A;
                        display_nxt = key_ext;
                    end
                end

                S_ENTER_A: begin
                    display_nxt = key_ext;
                    if (i_b_calc_ctrl_overflow_flag) begin
                        state_nxt   = S_ERROR;
                        display_nxt = DISP_ERR;
                    end else if (i_b_calc_ctrl_op_key) begin
                        state_nxt     = S_ENTER_B;
                        operand_a_nxt = i_b_calc_ctrl_keycode;
                        opcode_nxt    = i_b_calc_ctrl_op_code;
                        op_pulse_nxt  = 1'b1;
                        got_b_nxt     = 1'b0;
                    end
                end

                S_ENTER_B: begin
                    if (i_b_calc_ctrl_overflow_flag) begin
                        state_nxt   = S_ERROR;
                        display_nxt = DISP_ERR;
                    end else if (i_b_calc_ctrl_eq_key && got_b) begin
                        state_nxt     = S_EXEC;
                        operand_b_nxt = i_b_calc_ctrl_keycode;
                        alu_req_nxt   = 1'b1;
                        cnt_nxt       = '0;
                    end else begin
                        if (i_b_calc_ctrl_op_key) begin
                            opcode_nxt = i_b_calc_ctrl_op_code;
                        end
                        // Operand A stays on the display until operand B
                        // receives its first digit.
                        if (i_b_calc_ctrl_new_input || got_b) begin
                            got_b_nxt   = 1'b1;
                            display_nxt = key_ext;
                        end else begin
                            display_nxt = {{(P_RESULT_W-8){1'b0}}, operand_a};
                        end
                    end
                end

                S_EXEC: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (i_b_calc_ctrl_alu_ack) begin
                        if (i_b_calc_ctrl_alu_error) begin
                            state_nxt   = S_ERROR;
                            display_nxt = DISP_ERR;
                        end else begin
                            state_nxt     = S_RESULT;
                            display_nxt   = i_b_calc_ctrl_alu_result;
                            hex_clear_nxt = 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = S_ERROR;
                        display_nxt = DISP_ERR;
                    end else begin
                        alu_req_nxt = 1'b1;
                    end
                end

                S_RESULT: begin
                    if (i_b_calc_ctrl_op_key) begin
                        // Only a result that fits in a byte can become operand A.
                        if (display[P_RESULT_W-1:8] == '0) begin
                            state_nxt     = S_ENTER_B;
                            operand_a_nxt = display[7:0];
                            opcode_nxt    = i_b_calc_ctrl_op_code;
                            op_pulse_nxt  = 1'b1;
                            got_b_nxt     = 1'b0;
                        end else begin
                            state_nxt   = S_ERROR;
                            display_nxt = DISP_ERR;
                        end
                    end else if (i_b_calc_ctrl_new_input) begin
                        state_nxt     = S_ENTER_A;
                        operand_a_nxt = '0;
                        operand_b_nxt = '0;
                        display_nxt   = key_ext;
                    end
                end

                S_ERROR: begin
                    display_nxt = DISP_ERR;
                end

                default: begin
                    state_nxt   = S_IDLE;
                    display_nxt = '0;
                end
            endcase
        end

        error_nxt = (state_nxt == S_ERROR);
    end

    assign o_b_calc_ctrl_hex_clear            = hex_clear;
    assign o_b_calc_ctrl_op_valid_key_pressed = op_pulse;
    assign o_b_calc_ctrl_alu_req              = alu_req;
    assign o_b_calc_ctrl_operand_a            = operand_a;
    assign o_b_calc_ctrl_operand_b            = operand_b;
    assign o_b_calc_ctrl_opcode               = opcode;
    assign o_b_calc_ctrl_display              = display;
    assign o_b_calc_ctrl_state                = state;
    assign o_b_calc_ctrl_error                = error;

endmodule

// File: tb/tb_b_calc_ctrl.sv
// Testbench for b_calc_ctrl: directed scenarios with literal expectations,
// then randomized key/ALU traffic compared every cycle against a
// behavioural model of the calculator sequencing rules.

module tb_b_calc_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  keycode = '0;
    logic        new_input = 1'b0, ovf = 1'b0, op_key = 1'b0;
    logic [1:0]  op_code = '0;
    logic        eq_key = 1'b0, clr_key = 1'b0, ack = 1'b0, alu_err = 1'b0;
    logic [15:0] res = '0;

    logic        d_hc, d_opv, d_req, d_err;
    logic [7:0]  d_a, d_b;
    logic [1:0]  d_opc;
    logic [15:0] d_disp;
    logic [2:0]  d_state;

    b_calc_ctrl #(.P_TIMEOUT_CYCLES(TO), .P_RESULT_W(16)) dut (
        .i_sys_clock                        (clk),
        .i_sys_reset                        (rst),
        .i_b_calc_ctrl_keycode              (keycode),
        .i_b_calc_ctrl_new_input            (new_input),
        .i_b_calc_ctrl_overflow_flag        (ovf),
        .i_b_calc_ctrl_op_key               (op_key),
        .i_b_calc_ctrl_op_code              (op_code),
        .i_b_calc_ctrl_eq_key               (eq_key),
        .i_b_calc_ctrl_clr_key              (clr_key),
        .i_b_calc_ctrl_alu_ack              (ack),
        .i_b_calc_ctrl_alu_result           (res),
        .i_b_calc_ctrl_alu_error            (alu_err),
        .o_b_calc_ctrl_hex_clear            (d_hc),
        .o_b_calc_ctrl_op_valid_key_pressed (d_opv),
        .o_b_calc_ctrl_alu_req              (d_req),
        .o_b_calc_ctrl_operand_a            (d_a),
        .o_b_calc_ctrl_operand_b            (d_b),
        .o_b_calc_ctrl_opcode               (d_opc),
        .o_b_calc_ctrl_display              (d_disp),
        .o_b_calc_ctrl_state                (d_state),
        .o_b_calc_ctrl_error                (d_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int req_hi = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode numbers are the visible state codes.
    int          m_mode = 0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [1:0]  m_opc = '0;
    logic [15:0] m_disp = '0;
    logic        m_req = 1'b0, m_hc = 1'b0, m_opv = 1'b0, m_gotb = 1'b0;
    int          m_reqcyc = 0;

    task automatic to_error();
        m_mode = 6;
        m_disp = 16'hEEEE;
        m_req  = 1'b0;
    endtask

    task automatic model_step();
        m_hc  = 1'b0;
        m_opv = 1'b0;
        if (rst) begin
            m_mode = 0; m_a = '0; m_b = '0; m_opc = '0; m_disp = '0;
            m_req = 1'b0; m_gotb = 1'b0; m_reqcyc = 0;
        end else if (clr_key) begin
            m_hc = 1'b1; m_mode = 0; m_a = '0; m_b = '0; m_opc = '0;
            m_disp = '0; m_req = 1'b0; m_reqcyc = 0;
        end else begin
            case (m_mode)
                0: begin
                    m_disp = '0;
                    if (new_input) begin
                        m_mode = 1;
                        m_disp = {8'h00, keycode};
                    end
                end
                1: begin
                    if (ovf) to_error();
                    else begin
                        m_disp = {8'h00, keycode};
                        if (op_key) begin
                            m_a = keycode; m_opc = op_code; m_opv = 1'b1;
                            m_gotb = 1'b0; m_mode = 3;
                        end
                    end
                end
                3: begin
                    if (ovf) to_error();
                    else if (eq_key && m_gotb) begin
                        m_b = keycode; m_mode = 4; m_req = 1'b1; m_reqcyc = 0;
                    end else begin
                        if (op_key) m_opc = op_code;
                        if (new_input) m_gotb = 1'b1;
                        m_disp = m_gotb ? {8'h00, keycode} : {8'h00, m_a};
                    end
                end
                4: begin
                    m_reqcyc++;
                    if (ack) begin
                        if (alu_err) to_error();
                        else begin
                            m_mode = 5; m_req = 1'b0; m_disp = res; m_hc = 1'b1;
                        end
                    end else if (m_reqcyc == TO) begin
                        to_error();
                    end
                end
                5: begin
                    if (op_key) begin
                        if (m_disp < 16'd256) begin
                            m_a = m_disp[7:0]; m_opc = op_code; m_opv = 1'b1;
                            m_gotb = 1'b0; m_mode = 3;
                        end else to_error();
                    end else if (new_input) begin
                        m_a = '0; m_b = '0; m_mode = 1; m_disp = {8'h00, keycode};
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Per-cycle compare against the model, 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (d_req) req_hi++;
            check("cycle",
                  {d_state, d_err, d_req, d_hc, d_opv, d_opc, d_a, d_b, d_disp},
                  {3'(m_mode), (m_mode == 6), m_req, m_hc, m_opv, m_opc, m_a, m_b, m_disp});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask
    task automatic digit(input logic [7:0] k);
        keycode = k; new_input = 1'b1; cyc(); new_input = 1'b0;
    endtask
    task automatic op(input logic [1:0] c);
        op_code = c; op_key = 1'b1; cyc(); op_key = 1'b0;
    endtask
    task automatic eq();
        eq_key = 1'b1; cyc(); eq_key = 1'b0;
    endtask
    task automatic clr();
        clr_key = 1'b1; cyc(); clr_key = 1'b0;
    endtask
    task automatic alu(input logic [15:0] r, input logic e);
        res = r; alu_err = e; ack = 1'b1; cyc(); ack = 1'b0; alu_err = 1'b0;
    endtask

    int r;

    initial begin
        rst = 1'b1;
        cyc(); cyc();
        check("rst_state", d_state, 3'd0);
        check("rst_disp", d_disp, 16'h0000);
        check("rst_outs", {d_req, d_hc, d_opv, d_err, d_a, d_b, d_opc}, '0);
        rst = 1'b0;

        // F5 + 09, ALU answers on the third request cycle
        digit(8'h0F); digit(8'hF5); op(2'b00);
        check("t1_opv", d_opv, 1'b1);
        check("t1_state_b", d_state, 3'd3);
        digit(8'h00); digit(8'h09);
        req_hi = 0;
        eq();
        check("t1_exec", {d_state, d_req, d_a, d_b}, {3'd4, 1'b1, 8'hF5, 8'h09});
        cyc(); cyc();
        alu(16'h00FE, 1'b0);
        check("t1_result", {d_state, d_disp, d_hc, d_req}, {3'd5, 16'h00FE, 1'b1, 1'b0});
        check("t1_req_cycles", req_hi, 3);
        cyc();
        check("t1_hc_once", d_hc, 1'b0);

        // operand overflow, then clear
        clr();
        digit(8'h09); digit(8'h99);
        ovf = 1'b1; digit(8'h99);
        check("t2_error", {d_state, d_err, d_disp}, {3'd6, 1'b1, 16'hEEEE});
        ovf = 1'b0;
        clr();
        check("t2_clr", {d_state, d_hc, d_err, d_disp, d_a, d_b, d_opc}, {3'd0, 1'b1, 1'b0, 16'h0, 8'h0, 8'h0, 2'b0});
        cyc();
        check("t2_hc_once", d_hc, 1'b0);

        // ALU never answers: timeout, then a late ack is ignored
        digit(8'h12); op(2'b00); digit(8'h03);
        req_hi = 0;
        eq();
        repeat (20) cyc();
        check("t3_req_cycles", req_hi, TO);
        check("t3_error", {d_state, d_req}, {3'd6, 1'b0});
        alu(16'h0055, 1'b0);
        cyc();
        check("t3_late_ack", {d_state, d_disp}, {3'd6, 16'hEEEE});

        // result chaining
        clr();
        digit(8'h05); op(2'b00); digit(8'h0F); eq(); cyc();
        alu(16'h0014, 1'b0);
        check("t4_result", {d_state, d_disp}, {3'd5, 16'h0014});
        op(2'b01);
        check("t4_chain", {d_state, d_opv, d_a, d_opc, d_disp}, {3'd3, 1'b1, 8'h14, 2'b01, 16'h0014});
        digit(8'h04); eq();
        check("t4_exec", {d_state, d_a, d_b, d_opc}, {3'd4, 8'h14, 8'h04, 2'b01});
        alu(16'h0100, 1'b0);
        check("t4_big", d_disp, 16'h0100);
        op(2'b10);
        check("t4_big_chain", d_state, 3'd6);

        // eq before any B digit; eq+op together
        clr();
        digit(8'h07); op(2'b00); eq();
        check("t5_eq_ignored", d_state, 3'd3);
        digit(8'h02);
        eq_key = 1'b1; op_key = 1'b1; op_code = 2'b11;
        cyc();
        eq_key = 1'b0; op_key = 1'b0;
        check("t5_eq_wins", {d_state, d_opc}, {3'd4, 2'b00});

        // reset while requesting, late ack, then an ALU error
        cyc();
        check("t6_req_before_rst", d_req, 1'b1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("t6_rst", {d_state, d_req, d_disp, d_a, d_b, d_err, d_opc}, '0);
        alu(16'h0033, 1'b1);
        check("t6_late_ack", d_state, 3'd0);
        digit(8'h01); op(2'b11); digit(8'h00); eq();
        alu(16'h0000, 1'b1);
        check("t6_alu_err", {d_state, d_err, d_disp}, {3'd6, 1'b1, 16'hEEEE});

        // randomized traffic, checked by the per-cycle model compare
        clr();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            rst = ($urandom_range(0, 599) == 0);
            new_input = 1'b0; op_key = 1'b0; eq_key = 1'b0; clr_key = 1'b0;
            if (r < 3) clr_key = 1'b1;
            else if (r < 33) begin new_input = 1'b1; keycode = 8'($urandom); end
            else if (r < 45) begin op_key = 1'b1; op_code = 2'($urandom); end
            else if (r < 58) eq_key = 1'b1;
            ovf = ($urandom_range(0, 39) == 0);
            ack = d_req ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 29) == 0);
            res = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            alu_err = ($urandom_range(0, 5) == 0);
            cyc();
        end
        rst = 1'b0; new_input = 1'b0; op_key = 1'b0; eq_key = 1'b0;
        clr_key = 1'b0; ovf = 1'b0; ack = 1'b0; alu_err = 1'b0;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
